// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, debug-loadable instruction memory and the
// IF/ID pipeline register, steered by stall/halt/branch/jump feedback from decode.
module if_stage #(
  parameter int          IMEM_ADDR_W = 8,
  parameter logic [31:0] NOP_WORD    = 32'h00000000
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_stall,
  input  logic                   i_pc_src,
  input  logic [31:0]            i_beq_jump_dir,
  input  logic                   i_jump,
  input  logic                   i_jump_sel,
  input  logic [31:0]            i_jr_target,
  input  logic                   i_halt,
  input  logic                   i_du_imem_we,
  input  logic [IMEM_ADDR_W-1:0] i_du_imem_addr,
  input  logic [31:0]            i_du_imem_data,
  output logic [31:0]            o_instruction,
  output logic [31:0]            o_pc_plus_4,
  output logic [31:0]            o_pc,
  output logic                   o_halted
);

  localparam int IMEM_DEPTH = 1 << IMEM_ADDR_W;

  logic [31:0] r_imem [IMEM_DEPTH];

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_plus_4;
  logic        r_halted;

  logic [31:0] w_pc_next;
  logic [31:0] w_instr_next;
  logic [31:0] w_pc_plus_4_next;
  logic        w_halted_next;

  logic [IMEM_ADDR_W-1:0] w_fetch_idx;
  logic [31:0]            w_fetch_word;
  logic [31:0]            w_seq_pc;
  logic [31:0]            w_j_target;
  logic [31:0]            w_jr_target;
  logic                   w_update;
  logic                   w_unused;

  // Debug-unit write port; never gated, so code can be loaded while held in reset.
  always_ff @(posedge i_clk) begin
    if (i_du_imem_we) begin
      r_imem[i_du_imem_addr] <= i_du_imem_data;
    end
  end

  // Asynchronous read: a same-edge write is seen by the next fetch, not this one.
  assign w_fetch_idx  = r_pc[IMEM_ADDR_W+1:2];
  assign w_fetch_word = r_imem[w_fetch_idx];

  assign w_seq_pc    = r_pc + 32'd4;
  assign w_j_target  = {r_pc_plus_4[31:28], r_instr[25:0], 2'b00};
  assign w_jr_target = {i_jr_target[31:2], 2'b00};
  assign w_update    = i_enable & ~r_halted;
  assign w_unused    = ^i_jr_target[1:0];

  always_comb begin
    w_pc_next        = r_pc;
    w_instr_next     = r_instr;
    w_pc_plus_4_next = r_pc_plus_4;
    w_halted_next    = r_halted;
    // Stall outranks everything: decode's redirect operands may be stale while it stalls.
    if (w_update && !i_stall) begin
      if (i_halt) begin
        w_halted_next    = 1'b1;
        w_instr_next     = NOP_WORD;
        w_pc_plus_4_next = 32'd0;
      end else if (i_pc_src) begin
        w_pc_next        = i_beq_jump_dir;
        w_instr_next     = NOP_WORD;
        w_pc_plus_4_next = 32'd0;
      end else if (i_jump_sel) begin
        w_pc_next        = w_jr_target;
        w_instr_next     = NOP_WORD;
        w_pc_plus_4_next = 32'd0;
      end else if (i_jump) begin
        w_pc_next        = w_j_target;
        w_instr_next     = NOP_WORD;
        w_pc_plus_4_next = 32'd0;
      end else begin
        w_pc_next        = w_seq_pc;
        w_instr_next     = w_fetch_word;
        w_pc_plus_4_next = w_seq_pc;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc        <= 32'd0;
      r_instr     <= NOP_WORD;
      r_pc_plus_4 <= 32'd0;
      r_halted    <= 1'b0;
    end else begin
      r_pc        <= w_pc_next;
      r_instr     <= w_instr_next;
      r_pc_plus_4 <= w_pc_plus_4_next;
      r_halted    <= w_halted_next;
    end
  end

  assign o_instruction = r_instr;
  assign o_pc_plus_4   = r_pc_plus_4;
  assign o_pc          = r_pc;
  assign o_halted      = r_halted;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage.
- Holds the PC and a word-addressed instruction memory, loaded by the debug unit.
- Contains the IF/ID pipeline register.
- Applies branch/jump/JR redirects, hazard stalls, flushes and halt coming back from decode.

Parameters:
- IMEM_ADDR_W, 8, instruction-memory word-address width; depth = 2^IMEM_ADDR_W words.
- NOP_WORD, 32'h00000000, instruction injected into IF/ID on flush/halt.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  debug-unit run/step gate; 0 = PC, IF/ID and halt flag hold.
- i_stall  in  1  hazard-unit stall from decode.
- i_pc_src  in  1  taken conditional branch from decode.
- i_beq_jump_dir  in  32  branch target from decode.
- i_jump  in  1  J/JAL from decode.
- i_jump_sel  in  1  JR/JALR from decode.
- i_jr_target  in  32  forwarded rs value, used as the JR target.
- i_halt  in  1  halt decoded in ID.
- i_du_imem_we  in  1  debug-unit instruction-memory write enable.
- i_du_imem_addr  in  IMEM_ADDR_W  debug-unit word address.
- i_du_imem_data  in  32  debug-unit write data.
- o_instruction  out  32  IF/ID instruction.
- o_pc_plus_4  out  32  IF/ID PC+4.
- o_pc  out  32  current PC, for debug readout.
- o_halted  out  1  sticky halt flag.

Behaviour:
Reset:
- PC=0, o_instruction=NOP_WORD, o_pc_plus_4=0, o_halted=0.
- Instruction memory contents are not reset.

Fetch:
- Memory read is asynchronous at word index pc[IMEM_ADDR_W+1:2].
- Upper PC bits are ignored, so the index wraps modulo depth.
- The fetched word and pc+4 (32-bit wraparound) are captured in IF/ID at the clock edge, giving 1-cycle latency from PC to o_instruction.

Update gating:
- An update occurs only when i_enable=1 and o_halted=0.
- Otherwise PC, IF/ID and o_halted hold.

Priority within an enabled cycle (highest first):
1. i_stall=1: PC and IF/ID hold. All redirect inputs and i_halt are ignored that cycle, because their operands may be stale.
2. i_halt=1: o_halted<=1, PC holds, IF/ID<=NOP_WORD/0. Cleared only by i_reset.
3. i_pc_src=1: PC<=i_beq_jump_dir, IF/ID<=NOP_WORD/0 (flush).
4. i_jump_sel=1: PC<={i_jr_target[31:2],2'b00}, flush.
5. i_jump=1: PC<={o_pc_plus_4[31:28], o_instruction[25:0], 2'b00}, flush. The J target is taken from the IF/ID instruction word currently in decode.
6. Otherwise: PC<=pc+4, IF/ID<=fetched word/pc+4.

Redirect cost: one bubble. The instruction fetched in the redirect cycle is discarded; no delay slot is executed.

Debug-unit write path:
- When i_du_imem_we=1, mem[i_du_imem_addr]<=i_du_imem_data at the edge.
- Writes are accepted regardless of i_enable, halt or reset.
- Write and fetch of the same word in the same cycle: IF/ID captures the old contents (read-before-write).

o_pc is the registered PC; it shows the redirect target one cycle after the redirect is asserted.

Test Plan:
1. Reset then load mem[0..3]=32'h20010005, 32'h20020003, 32'h00221820, 32'hFC000000 via the DU port; hold i_enable=1 for 4 cycles -> o_instruction shows those words in order, o_pc_plus_4=4,8,12,16, o_pc=16.
2. Assert i_stall for 2 cycles while o_instruction=32'h20020003 -> o_pc, o_instruction and o_pc_plus_4 are frozen both cycles, and fetch resumes with 32'h00221820.
3. i_pc_src=1 with i_beq_jump_dir=32'h40 at PC=8 -> next o_instruction=32'h0 and o_pc=32'h40; the following cycle shows mem[16].
4. Same cycle: i_pc_src=1 (target 32'h40), i_jump_sel=1 (i_jr_target=32'h83), i_stall=0 -> PC=32'h40. Repeat with i_stall=1 -> PC unchanged, no flush.
5. i_jump=1 with o_instruction=32'h08000010 and o_pc_plus_4=32'h0000000C -> PC=32'h40, IF/ID flushed to NOP.
6. i_halt=1 -> o_halted=1, PC frozen, o_instruction=0 for 10 further cycles despite pc_src/jump pulses; i_reset -> PC=0, o_halted=0. Separately, i_enable=0 for 3 cycles -> all state holds.
